// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state/grant types and default widths for the SDRAM port arbiter
package sdram_arb_pkg;
  localparam int AW_DEF = 25;
  localparam int DW_DEF = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
  typedef enum logic {GNT_LD, GNT_VF} gnt_t;
endpackage

// File: rtl/sdram_port_arb.sv
// sdram_port_arb: round-robin sharing of one SDRAM port between loader writes and cached VFD reads
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF,
  parameter int TMO = 1023
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_wr,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_din,
  output logic          ld_wait,
  input  logic          vf_rd,
  input  logic [AW-1:0] vf_addr,
  output logic [DW-1:0] vf_dout,
  output logic          vf_valid,
  output logic          vf_busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_ack,
  output logic          err
);
  localparam int CW = $clog2(TMO + 1);
  arb_state_t    state_q, state_d;
  gnt_t          gnt_q, gnt_d, last_q, last_d;
  logic          ld_pend_q, ld_pend_d, vf_pend_q, vf_pend_d;
  logic [AW-1:0] ld_addr_q, ld_addr_d, vf_addr_q, vf_addr_d, tag_q, tag_d;
  logic [DW-1:0] ld_din_q, ld_din_d, cdat_q, cdat_d;
  logic          cval_q, cval_d, vf_valid_q, vf_valid_d;
  logic [DW-1:0] vf_dout_q, vf_dout_d, mem_din_q, mem_din_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d, mem_rd_q, mem_rd_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit, tmo, done;

  always_comb begin
    hit        = vf_rd && !vf_pend_q && cval_q && vf_addr == tag_q;
    // counter starts at 0 on the first WAIT cycle, so err lands TMO cycles after the issue pulse
    tmo        = state_q == WAIT && !mem_ack && cnt_q == CW'(TMO - 2);
    done       = state_q == WAIT && (mem_ack || tmo);
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    ld_pend_d  = ld_pend_q;
    ld_addr_d  = ld_addr_q;
    ld_din_d   = ld_din_q;
    vf_pend_d  = vf_pend_q;
    vf_addr_d  = vf_addr_q;
    tag_d      = tag_q;
    cdat_d     = cdat_q;
    cval_d     = cval_q;
    vf_valid_d = hit;
    vf_dout_d  = hit ? cdat_q : vf_dout_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    mem_rd_d   = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;
    if (ld_wr && !ld_pend_q) begin
      ld_pend_d = 1'b1;
      ld_addr_d = ld_addr;
      ld_din_d  = ld_din;
    end
    if (vf_rd && !vf_pend_q && !hit) begin
      vf_pend_d = 1'b1;
      vf_addr_d = vf_addr;
    end
    case (state_q)
      IDLE: if (ld_pend_q || vf_pend_q) begin
        gnt_d      = !vf_pend_q ? GNT_LD : !ld_pend_q ? GNT_VF : last_q == GNT_VF ? GNT_LD : GNT_VF;
        last_d     = gnt_d;
        state_d    = ISSUE;
        mem_addr_d = gnt_d == GNT_LD ? ld_addr_q : vf_addr_q;
        mem_din_d  = gnt_d == GNT_LD ? ld_din_q : mem_din_q;
        mem_we_d   = gnt_d == GNT_LD;
        mem_rd_d   = gnt_d == GNT_VF;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
        cval_d  = cval_q && !(gnt_q == GNT_LD && ld_addr_q == tag_q);
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        err_d = err_q || tmo;
        if (done) begin
          state_d = IDLE;
          if (gnt_q == GNT_LD) ld_pend_d = 1'b0;
          else begin
            vf_pend_d  = 1'b0;
            vf_valid_d = 1'b1;
            vf_dout_d  = mem_ack ? mem_dout : '0;
            tag_d      = mem_ack ? vf_addr_q : tag_q;
            cdat_d     = mem_ack ? mem_dout : cdat_q;
            cval_d     = cval_q || mem_ack;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_LD;
      last_q     <= GNT_VF;
      ld_pend_q  <= 1'b0;
      ld_addr_q  <= '0;
      ld_din_q   <= '0;
      vf_pend_q  <= 1'b0;
      vf_addr_q  <= '0;
      tag_q      <= '0;
      cdat_q     <= '0;
      cval_q     <= 1'b0;
      vf_valid_q <= 1'b0;
      vf_dout_q  <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      ld_pend_q  <= ld_pend_d;
      ld_addr_q  <= ld_addr_d;
      ld_din_q   <= ld_din_d;
      vf_pend_q  <= vf_pend_d;
      vf_addr_q  <= vf_addr_d;
      tag_q      <= tag_d;
      cdat_q     <= cdat_d;
      cval_q     <= cval_d;
      vf_valid_q <= vf_valid_d;
      vf_dout_q  <= vf_dout_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      mem_rd_q   <= mem_rd_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ld_wait  = ld_pend_q && ld_pend_d && !reset;
  assign vf_busy  = vf_pend_q;
  assign vf_valid = vf_valid_q;
  assign vf_dout  = vf_dout_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
  assign mem_rd   = mem_rd_q;
  assign err      = err_q;
endmodule
